// File: rtl/pic_pkg.sv
// pic_pkg: shared state encoding, spurious level and one-hot encoder for the 8259 INTA/EOI path
package pic_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, ACK1 = 2'd2} state_t;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  function automatic logic [2:0] onehot_to_level(input logic [7:0] v);
    logic [2:0] l;
    l = '0;
    for (int i = 0; i < 8; i++) if (v[i]) l = 3'(i);
    return l;
  endfunction
endpackage

// File: rtl/isr_highest_finder.sv
// isr_highest_finder: highest-priority set ISR bit, searching upward from priority_rotate
module isr_highest_finder (
  input  logic [7:0] isr,
  input  logic [2:0] priority_rotate,
  output logic [3:0] result
);
  logic [2:0] idx;
  always_comb begin
    result = '0;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = priority_rotate + 3'(i);
      if (isr[idx]) result = {1'b1, idx};
    end
  end
endmodule

// File: rtl/interrupt_ack_control.sv
// interrupt_ack_control: INTA handshake, ISR ownership and EOI/rotation for the 8259 PIC
module interrupt_ack_control
  import pic_pkg::*;
#(
  parameter logic [2:0] RESET_ROTATE = 3'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] interrupt_vector,
  input  logic       inta_pulse,
  input  logic [4:0] vector_base,
  input  logic       aeoi_mode,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic       eoi_rotate,
  input  logic [2:0] eoi_level,
  output logic       int_out,
  output logic [7:0] isr,
  output logic [2:0] priority_rotate,
  output logic [7:0] clear_irr,
  output logic [7:0] data_out,
  output logic       data_out_en
);
  state_t state;
  logic [2:0] level, eoi_lvl, new_level;
  logic spurious, eoi_hit, inta1, inta2;
  logic [3:0] hi;
  logic [7:0] eoi_clr, aeoi_clr, inta_set;
  isr_highest_finder u_find (.isr(isr), .priority_rotate(priority_rotate), .result(hi));
  always_comb begin
    eoi_lvl = eoi_specific ? eoi_level : hi[2:0];
    eoi_hit = eoi_valid && (eoi_specific || hi[3]);
    eoi_clr = eoi_hit ? 8'b1 << eoi_lvl : '0;
    inta1 = state == REQ && inta_pulse;
    inta2 = state == ACK1 && inta_pulse;
    new_level = |interrupt_vector ? onehot_to_level(interrupt_vector) : SPURIOUS_LEVEL;
    inta_set = inta1 && |interrupt_vector ? 8'b1 << new_level : '0;
    aeoi_clr = inta2 && aeoi_mode && !spurious ? 8'b1 << level : '0;
  end
  // EOI/AEOI clears act on the old ISR; the INTA set is ORed in last so it wins a collision
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      level <= '0;
      spurious <= 1'b0;
      int_out <= 1'b0;
      isr <= '0;
      priority_rotate <= RESET_ROTATE;
      clear_irr <= '0;
      data_out <= '0;
      data_out_en <= 1'b0;
    end else begin
      isr <= (isr & ~(eoi_clr | aeoi_clr)) | inta_set;
      if (eoi_hit && eoi_rotate) priority_rotate <= eoi_lvl + 3'd1;
      clear_irr <= inta_set;
      data_out_en <= inta2;
      if (inta2) data_out <= {vector_base, level};
      case (state)
        IDLE: if (|interrupt_vector) begin
          state <= REQ;
          int_out <= 1'b1;
        end
        REQ: if (inta_pulse) begin
          level <= new_level;
          spurious <= ~|interrupt_vector;
          int_out <= 1'b0;
          state <= ACK1;
        end
        ACK1: if (inta_pulse) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_interrupt_ack_control.sv
// tb_interrupt_ack_control: directed scenarios with hand-computed expectations
module tb_interrupt_ack_control;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] interrupt_vector = '0;
  logic inta_pulse = 1'b0, aeoi_mode = 1'b0;
  logic [4:0] vector_base = 5'h08;
  logic eoi_valid = 1'b0, eoi_specific = 1'b0, eoi_rotate = 1'b0;
  logic [2:0] eoi_level = '0;
  logic int_out, data_out_en;
  logic [7:0] isr, clear_irr, data_out;
  logic [2:0] priority_rotate;
  int checks = 0, fails = 0;
  interrupt_ack_control dut (
    .clk(clk), .reset(reset), .interrupt_vector(interrupt_vector), .inta_pulse(inta_pulse),
    .vector_base(vector_base), .aeoi_mode(aeoi_mode), .eoi_valid(eoi_valid),
    .eoi_specific(eoi_specific), .eoi_rotate(eoi_rotate), .eoi_level(eoi_level),
    .int_out(int_out), .isr(isr), .priority_rotate(priority_rotate), .clear_irr(clear_irr),
    .data_out(data_out), .data_out_en(data_out_en)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_seq(input logic [7:0] v);
    interrupt_vector = v;
    tick();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    interrupt_vector = '0;
    tick();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    tick();
  endtask
  task automatic eoi(input logic spec, input logic rot, input logic [2:0] lvl);
    eoi_valid = 1'b1;
    eoi_specific = spec;
    eoi_rotate = rot;
    eoi_level = lvl;
    tick();
    eoi_valid = 1'b0;
    eoi_specific = 1'b0;
    eoi_rotate = 1'b0;
  endtask
  task automatic test_reset();
    #2;
    checks++;
    if ({int_out, isr, priority_rotate, clear_irr, data_out, data_out_en} !== 29'd0) begin
      fails++;
      $display("FAIL reset_values got int=%b isr=%h rot=%0d clr=%h d=%h en=%b want all 0", int_out, isr, priority_rotate, clear_irr, data_out, data_out_en);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic test_basic();
    interrupt_vector = 8'h04;
    tick();
    checks++;
    if (int_out !== 1'b1) begin fails++; $display("FAIL basic_int_out got %b want 1", int_out); end
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    interrupt_vector = '0;
    checks++;
    if ({isr, clear_irr, int_out} !== {8'h04, 8'h04, 1'b0}) begin
      fails++;
      $display("FAIL basic_inta1 got isr=%h clr=%h int=%b want 04 04 0", isr, clear_irr, int_out);
    end
    tick();
    checks++;
    if (clear_irr !== 8'h00) begin fails++; $display("FAIL basic_clr_pulse got %h want 00", clear_irr); end
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    checks++;
    if ({data_out, data_out_en} !== {8'h42, 1'b1}) begin
      fails++;
      $display("FAIL basic_inta2 got d=%h en=%b want 42 1", data_out, data_out_en);
    end
    tick();
    checks++;
    if ({data_out_en, isr} !== {1'b0, 8'h04}) begin
      fails++;
      $display("FAIL basic_en_pulse got en=%b isr=%h want 0 04", data_out_en, isr);
    end
  endtask
  task automatic test_aeoi();
    eoi(1'b0, 1'b0, 3'd0);
    checks++;
    if (isr !== 8'h00) begin fails++; $display("FAIL aeoi_pre_clear got %h want 00", isr); end
    aeoi_mode = 1'b1;
    interrupt_vector = 8'h10;
    tick();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    interrupt_vector = '0;
    checks++;
    if (isr !== 8'h10) begin fails++; $display("FAIL aeoi_set got %h want 10", isr); end
    tick();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    checks++;
    if ({isr, data_out, data_out_en} !== {8'h00, 8'h44, 1'b1}) begin
      fails++;
      $display("FAIL aeoi_clear got isr=%h d=%h en=%b want 00 44 1", isr, data_out, data_out_en);
    end
    aeoi_mode = 1'b0;
    tick();
  endtask
  task automatic test_eoi();
    run_seq(8'h02);
    run_seq(8'h08);
    checks++;
    if (isr !== 8'h0A) begin fails++; $display("FAIL eoi_setup got %h want 0a", isr); end
    eoi(1'b0, 1'b0, 3'd0);
    checks++;
    if ({isr, priority_rotate} !== {8'h08, 3'd0}) begin
      fails++;
      $display("FAIL eoi_nonspecific got isr=%h rot=%0d want 08 0", isr, priority_rotate);
    end
    run_seq(8'h02);
    eoi(1'b0, 1'b1, 3'd0);
    checks++;
    if ({isr, priority_rotate} !== {8'h08, 3'd2}) begin
      fails++;
      $display("FAIL eoi_rotating got isr=%h rot=%0d want 08 2", isr, priority_rotate);
    end
    eoi(1'b1, 1'b1, 3'd7);
    checks++;
    if ({isr, priority_rotate} !== {8'h08, 3'd0}) begin
      fails++;
      $display("FAIL eoi_wrap got isr=%h rot=%0d want 08 0", isr, priority_rotate);
    end
    eoi(1'b0, 1'b0, 3'd0);
    eoi(1'b0, 1'b1, 3'd5);
    checks++;
    if ({isr, priority_rotate} !== {8'h00, 3'd0}) begin
      fails++;
      $display("FAIL eoi_empty got isr=%h rot=%0d want 00 0", isr, priority_rotate);
    end
    eoi(1'b1, 1'b1, 3'd1);
    run_seq(8'h02);
    run_seq(8'h08);
    eoi(1'b0, 1'b0, 3'd0);
    checks++;
    if ({isr, priority_rotate} !== {8'h02, 3'd2}) begin
      fails++;
      $display("FAIL eoi_search_from_rot got isr=%h rot=%0d want 02 2", isr, priority_rotate);
    end
    eoi(1'b1, 1'b0, 3'd1);
  endtask
  task automatic test_spurious();
    interrupt_vector = 8'h04;
    tick();
    interrupt_vector = '0;
    tick();
    checks++;
    if (int_out !== 1'b1) begin fails++; $display("FAIL spur_int_hold got %b want 1", int_out); end
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    checks++;
    if ({isr, clear_irr, int_out} !== {8'h00, 8'h00, 1'b0}) begin
      fails++;
      $display("FAIL spur_inta1 got isr=%h clr=%h int=%b want 00 00 0", isr, clear_irr, int_out);
    end
    tick();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    checks++;
    if ({data_out, data_out_en, isr} !== {8'h47, 1'b1, 8'h00}) begin
      fails++;
      $display("FAIL spur_inta2 got d=%h en=%b isr=%h want 47 1 00", data_out, data_out_en, isr);
    end
    tick();
  endtask
  task automatic test_collision_reset();
    run_seq(8'h04);
    interrupt_vector = 8'h04;
    tick();
    inta_pulse = 1'b1;
    eoi(1'b1, 1'b0, 3'd2);
    inta_pulse = 1'b0;
    interrupt_vector = '0;
    checks++;
    if ({isr, clear_irr} !== {8'h04, 8'h04}) begin
      fails++;
      $display("FAIL collision_set_wins got isr=%h clr=%h want 04 04", isr, clear_irr);
    end
    checks++;
    if (priority_rotate !== 3'd2) begin fails++; $display("FAIL pre_reset_rot got %0d want 2", priority_rotate); end
    reset = 1'b1;
    #2;
    checks++;
    if ({int_out, isr, priority_rotate, clear_irr, data_out, data_out_en} !== 29'd0) begin
      fails++;
      $display("FAIL async_reset got int=%b isr=%h rot=%0d clr=%h d=%h en=%b want all 0", int_out, isr, priority_rotate, clear_irr, data_out, data_out_en);
    end
    tick();
    reset = 1'b0;
    tick();
    inta_pulse = 1'b1;
    tick();
    inta_pulse = 1'b0;
    tick();
    checks++;
    if ({data_out_en, isr, int_out, data_out} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
      fails++;
      $display("FAIL post_reset_inta got en=%b isr=%h int=%b d=%h want 0 00 0 00", data_out_en, isr, int_out, data_out);
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_aeoi();
    test_eoi();
    test_spurious();
    test_collision_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/interrupt_ack_control.md
# interrupt_ack_control

Sequential INTA/EOI control stage downstream of the priority resolver in the 8259 PIC. It consumes the resolver's one-hot `interrupt_vector` and raises `int_out` to the CPU. It then runs the two-pulse INTA sequence: it sets the in-service register, clears the serviced IRR bit and drives the vector byte. It also owns the ISR and `priority_rotate` values that feed back into the resolver, and executes EOI commands, including automatic EOI and rotation.

## Interface
- `RESET_ROTATE`, default 3'd0: `priority_rotate` value loaded on reset. Level 0 is highest priority.
- `clk` input 1: single system clock.
- `reset` input 1: asynchronous, active-high reset.
- `interrupt_vector` input 8: one-hot winning request from the priority resolver; all zeros means none.
- `inta_pulse` input 1: one-cycle strobe per CPU INTA pulse, already synchronised.
- `vector_base` input 5: ICW2 T7–T3.
- `aeoi_mode` input 1: automatic EOI enabled.
- `eoi_valid` input 1: one-cycle EOI command strobe.
- `eoi_specific` input 1: 1 = specific EOI using `eoi_level`; 0 = non-specific.
- `eoi_rotate` input 1: rotate priority on this EOI.
- `eoi_level` input 3: level for a specific EOI.
- `int_out` output 1: interrupt request to the CPU.
- `isr` output 8: in-service register, fed to the resolver.
- `priority_rotate` output 3: current highest-priority level, fed to the resolver.
- `clear_irr` output 8: one-cycle one-hot pulse that clears the serviced IRR bit.
- `data_out` output 8: vector byte.
- `data_out_en` output 1: `data_out` is valid this cycle.

## Operation
States:
- **IDLE**
  - `interrupt_vector != 0` → REQ.
  - `int_out` is registered, so it rises on the cycle after the vector is seen.
- **REQ**
  - `int_out = 1`.
  - `int_out` stays high even if `interrupt_vector` returns to 0.
  - `inta_pulse` → latch `level = encode(interrupt_vector)`.
    - If the vector is non-zero: set `isr[level]` and pulse `clear_irr[level]`.
    - If the vector is zero (spurious): set `level = 7`, set no ISR bit, issue no `clear_irr`.
  - Drop `int_out` and go to ACK1.
- **ACK1**
  - Next `inta_pulse` → drive `data_out = {vector_base, level}` with `data_out_en = 1` for exactly one cycle.
  - If `aeoi_mode` is set and the request was not spurious: clear `isr[level]`.
  - Go to IDLE.
- `inta_pulse` in IDLE is ignored.
- A vector that is non-zero again after ACK1 re-enters REQ through IDLE on the following cycle.

EOI (accepted in any state):
- Non-specific EOI clears the highest-priority set ISR bit, searching from `priority_rotate` upward modulo 8.
- Specific EOI clears `isr[eoi_level]`.
- With `eoi_rotate = 1`: `priority_rotate <= (cleared_level + 1) mod 8`, so the cleared level becomes lowest priority.
- Non-specific EOI with `isr == 0`: no ISR change and no rotation.
- Specific EOI on a bit that is already clear: ISR unchanged; rotation still applies if `eoi_rotate = 1`.
- Rotation arithmetic is 3-bit and wraps, so 7 + 1 = 0.

Simultaneous events:
- EOI clears are evaluated on the pre-cycle ISR; the INTA set is applied after them.
- If both target the same bit in the same cycle, the set wins.
- AEOI clear and EOI clear in the same cycle: both are applied (OR of clear masks).

Reset mid-sequence: returns immediately to IDLE and all outputs take their reset values. An in-flight `data_out` is abandoned.

## Timing
Reset values:
- `int_out = 0`, `isr = 0`, `priority_rotate = RESET_ROTATE`.
- `clear_irr = 0`, `data_out = 0`, `data_out_en = 0`, state IDLE.

Latencies:
- `interrupt_vector` → `int_out`: 1 cycle.
- First INTA → `isr` / `clear_irr` / `int_out` low: 1 cycle after the strobe.
- Second INTA → `data_out_en`: 1 cycle after the strobe.
- `eoi_valid` → `isr` / `priority_rotate` update: 1 cycle.

All outputs are registered. `clear_irr` and `data_out_en` are single-cycle pulses.

## Structure
- Shared package `pic_pkg`:
  - state enum (`IDLE`, `REQ`, `ACK1`);
  - `SPURIOUS_LEVEL = 3'd7`;
  - function `onehot_to_level` (8→3).
- Sub-module `isr_highest_finder`: combinational; takes `isr` and `priority_rotate` and returns `{found, level[2:0]}`. Used for non-specific EOI.

## Test plan
- **Basic sequence.** `vector_base = 5'h08`, `interrupt_vector = 8'h04`, then two `inta_pulse` strobes.
  - `int_out` rises 1 cycle after the vector.
  - After INTA1: `isr = 8'h04`, `clear_irr = 8'h04` for one cycle, `int_out = 0`.
  - After INTA2: `data_out = 8'h42`, `data_out_en` for one cycle.
- **AEOI.** Same stimulus with `aeoi_mode = 1` → `isr` returns to 0 the cycle after INTA2.
- **Non-specific EOI.** `isr = 8'h0A`, `priority_rotate = 0`, non-specific EOI → `isr = 8'h08`.
- **Rotating EOI.** Same with `eoi_rotate = 1` → `isr = 8'h08` and `priority_rotate = 2`.
  - Specific rotating EOI with level 7 → `priority_rotate = 0` (wrap).
- **Spurious request.** Vector drops to 0 while in REQ, then INTA, INTA.
  - `isr` unchanged, no `clear_irr`.
  - `data_out = {vector_base, 3'd7}`.
- **Collision and reset.**
  - Specific EOI on level 2 in the same cycle as INTA1 selecting level 2 → `isr[2] = 1` (set wins).
  - `reset` asserted in ACK1 → all outputs reset with no clock edge required; the second INTA after release is ignored.
